// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  localparam logic [3:0]  BE_NONE      = 4'b0000;
  localparam int unsigned DEF_AW       = 10;
  localparam int unsigned DEF_MAX_WAIT = 8;
  localparam int unsigned DEF_CW       = 8;

  // Byte write enables presented to the RAM for one command.
  function automatic logic [3:0] wr_mask(input logic we, input logic [3:0] be);
    return we ? be : BE_NONE;
  endfunction

endpackage

// File: rtl/arb_starve_timer.sv
// Aux starvation timer: counts blocked aux cycles and raises starve once
// the count has sat at MAX_WAIT for a blocked cycle.
module arb_starve_timer
  import dram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic aux_req,
  input  logic aux_ready,
  output logic starve
);

  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;

  // A withdrawn or served aux request clears everything, even on the edge
  // where starve would otherwise have been raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (!aux_req || aux_ready) begin
      wait_cnt <= '0;
      starve   <= 1'b0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      starve   <= 1'b1;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Single-port data RAM arbiter between CPU (priority) and aux master.
// Optional conflict statistics counter enabled by RAM_ARB_STATS_EN.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [3:0]    aux_be,
  input  logic [AW-1:0] aux_addr,
  input  logic [31:0]   aux_wdata,
  output logic          aux_ready,
  output logic          aux_rvalid,
  output logic [31:0]   aux_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_wea,
  input  logic [31:0]   ram_douta
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [CW-1:0] conflict_cnt
`endif
);

  logic   starve;
  logic   grant_cpu;
  logic   grant_aux;
  owner_t own_q1;
  owner_t own_q2;

  arb_starve_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CW       (CW)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .aux_req   (aux_req),
    .aux_ready (grant_aux),
    .starve    (starve)
  );

  // Grants are masked while reset is held so no transfer is offered.
  always_comb begin
    grant_cpu = 1'b0;
    grant_aux = 1'b0;
    if (!rst) begin
      if (starve) begin
        grant_aux = aux_req;
        grant_cpu = cpu_req && !aux_req;
      end else begin
        grant_cpu = cpu_req;
        grant_aux = aux_req && !cpu_req;
      end
    end
  end

  assign cpu_ready = grant_cpu;
  assign aux_ready = grant_aux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wea   <= BE_NONE;
      own_q1    <= OWN_NONE;
      own_q2    <= OWN_NONE;
    end else begin
      own_q2 <= own_q1;
      if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_wea   <= wr_mask(cpu_we, cpu_be);
        own_q1    <= cpu_we ? OWN_NONE : OWN_CPU;
      end else if (grant_aux) begin
        ram_addr  <= aux_addr;
        ram_wdata <= aux_wdata;
        ram_wea   <= wr_mask(aux_we, aux_be);
        own_q1    <= aux_we ? OWN_NONE : OWN_AUX;
      end else begin
        ram_wea   <= BE_NONE;
        own_q1    <= OWN_NONE;
      end
    end
  end

  // Read data lands one cycle after issue; only the tagged owner updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata <= '0;
      aux_rdata <= '0;
    end else begin
      if (own_q1 == OWN_CPU) cpu_rdata <= ram_douta;
      if (own_q1 == OWN_AUX) aux_rdata <= ram_douta;
    end
  end

  assign cpu_rvalid = (own_q2 == OWN_CPU);
  assign aux_rvalid = (own_q2 == OWN_AUX);

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (cpu_req && aux_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule
